// File: rtl/risc_pkg.sv
// Shared constants and opcode encoding for the VeriRISC datapath.
package risc_pkg;

   localparam int unsigned AWIDTH_DEF = 5;
   localparam int unsigned DWIDTH_DEF = 8;
   localparam int unsigned OPW        = 3;
   localparam int unsigned PHW        = 3;

   typedef enum logic [OPW-1:0] {
      OP_HLT = 3'd0,
      OP_SKZ = 3'd1,
      OP_ADD = 3'd2,
      OP_AND = 3'd3,
      OP_XOR = 3'd4,
      OP_LDA = 3'd5,
      OP_STO = 3'd6,
      OP_JMP = 3'd7
   } opcode_e;

endpackage

// File: rtl/risc_datapath_if.sv
// Controller/memory <-> datapath bus: decoded control lines, status back, memory port.
interface risc_datapath_if
   import risc_pkg::*;
#(
   parameter int unsigned AWIDTH = AWIDTH_DEF,
   parameter int unsigned DWIDTH = DWIDTH_DEF
);

   logic              sel;
   logic              rd;
   logic              ld_ir;
   logic              inc_pc;
   logic              halt;
   logic              ld_pc;
   logic              data_e;
   logic              ld_ac;
   logic              wr;
   logic [OPW-1:0]    opcode;
   logic [PHW-1:0]    phase;
   logic              zero;
   logic [AWIDTH-1:0] mem_addr;
   logic [DWIDTH-1:0] mem_rdata;
   logic [DWIDTH-1:0] mem_wdata;
   logic              mem_we;
   logic              halted;

   // Controller and memory side
   modport master (
      output sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr, mem_rdata,
      input  opcode, phase, zero, mem_addr, mem_wdata, mem_we, halted
   );

   // Datapath side
   modport slave (
      input  sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr, mem_rdata,
      output opcode, phase, zero, mem_addr, mem_wdata, mem_we, halted
   );

endinterface

// File: rtl/risc_alu.sv
// Combinational ALU: accumulator against memory read data, selected by opcode.
module risc_alu
   import risc_pkg::*;
#(
   parameter int unsigned DWIDTH = DWIDTH_DEF
) (
   input  opcode_e           opcode,
   input  logic [DWIDTH-1:0] ac,
   input  logic [DWIDTH-1:0] mem_rdata,
   output logic [DWIDTH-1:0] result
);

   // Non-arithmetic opcodes pass the accumulator through unchanged
   always_comb begin
      result = ac;
      case (opcode)
         OP_ADD:  result = ac + mem_rdata;
         OP_AND:  result = ac & mem_rdata;
         OP_XOR:  result = ac ^ mem_rdata;
         OP_LDA:  result = mem_rdata;
         default: result = ac;
      endcase
   end

endmodule

// File: rtl/risc_datapath.sv
// VeriRISC datapath: phase sequencer, PC, IR, accumulator, ALU and memory port.
module risc_datapath
   import risc_pkg::*;
#(
   parameter int unsigned AWIDTH = AWIDTH_DEF,
   parameter int unsigned DWIDTH = DWIDTH_DEF
) (
   input  logic            clk,
   input  logic            rst_,
   risc_datapath_if.slave  bus
);

   logic [PHW-1:0]    phase_q, phase_d;
   logic [AWIDTH-1:0] pc_q, pc_d;
   logic [DWIDTH-1:0] ir_q, ir_d;
   logic [DWIDTH-1:0] ac_q, ac_d;
   logic              halted_q, halted_d;
   logic [DWIDTH-1:0] alu_result_c;
   opcode_e           opcode_c;

   // rd and data_e only matter to a shared-bus memory; nothing to gate here
   logic              unused_ctl_c;
   assign unused_ctl_c = bus.rd ^ bus.data_e;

   assign opcode_c = opcode_e'(ir_q[DWIDTH-1 -: OPW]);

   risc_alu #(.DWIDTH(DWIDTH)) u_alu (
      .opcode    (opcode_c),
      .ac        (ac_q),
      .mem_rdata (bus.mem_rdata),
      .result    (alu_result_c)
   );

   // Next-state: everything freezes once halted; the halting edge itself still loads
   always_comb begin
      phase_d  = phase_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      ac_d     = ac_q;
      halted_d = halted_q;
      if (!halted_q) begin
         if (bus.ld_ir) ir_d = bus.mem_rdata;
         if (bus.ld_ac) ac_d = alu_result_c;
         if (bus.ld_pc)       pc_d = ir_q[AWIDTH-1:0];
         else if (bus.inc_pc) pc_d = pc_q + AWIDTH'(1);
         if (bus.halt) halted_d = 1'b1;
         else          phase_d  = phase_q + PHW'(1);
      end
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         phase_q  <= '0;
         pc_q     <= '0;
         ir_q     <= '0;
         ac_q     <= '0;
         halted_q <= 1'b0;
      end else begin
         phase_q  <= phase_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         ac_q     <= ac_d;
         halted_q <= halted_d;
      end
   end

   // Status back to the controller and the memory port
   assign bus.opcode    = opcode_c;
   assign bus.phase     = phase_q;
   assign bus.zero      = (ac_q == '0);
   assign bus.halted    = halted_q;
   assign bus.mem_addr  = bus.sel ? pc_q : ir_q[AWIDTH-1:0];
   assign bus.mem_wdata = ac_q;
   assign bus.mem_we    = bus.wr & ~halted_q;

endmodule
